// File: rtl/apb_mon_pkg.sv
// Shared types and constants for the APB protocol monitor: FSM state, error
// codes and small helpers that map between error codes and error bit vectors.
package apb_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } mon_state_e;

  localparam int NUM_ERR = 6;

  localparam logic [2:0] ERR_ENABLE_NO_SETUP = 3'd1;
  localparam logic [2:0] ERR_SETUP_NO_ENABLE = 3'd2;
  localparam logic [2:0] ERR_ACCESS_DROP     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT         = 3'd4;
  localparam logic [2:0] ERR_SLVERR          = 3'd5;
  localparam logic [2:0] ERR_UNSTABLE        = 3'd6;

  // Bit k of an error vector stands for error code k+1.
  function automatic logic [NUM_ERR-1:0] err_bit(input logic [2:0] code);
    return NUM_ERR'(1) << (code - 3'd1);
  endfunction

  function automatic logic [2:0] first_err(input logic [NUM_ERR-1:0] v);
    logic [2:0] code;
    code = '0;
    for (int k = NUM_ERR - 1; k >= 0; k--) begin
      if (v[k]) code = 3'(k + 1);
    end
    return code;
  endfunction

endpackage

// File: rtl/apb_mon_satcnt.sv
// Parametrised-width saturating counter; an increment on the same edge as a
// clear yields 1 so no event is lost across a clear.
module apb_mon_satcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d, base;

  always_comb begin
    base  = clr_i ? '0 : cnt_q;
    cnt_d = (inc_i && (base != '1)) ? base + W'(1) : base;
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples values from before the edge regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/apb_protocol_monitor.sv
// Passive APB slave-side protocol monitor with sticky error flags and
// saturating statistics. Define APB_MON_STABILITY_CHECK_EN to add the
// ACCESS-phase address/direction/write-data stability check (error 6).
module apb_protocol_monitor
  import apb_mon_pkg::*;
#(
  parameter int ADDR_W         = 13,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int WAIT_W         = 8,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pclken,
  input  logic               psel,
  input  logic               penable,
  input  logic [ADDR_W-1:0]  paddr,
  input  logic               pwrite,
  input  logic [DATA_W-1:0]  pwdata,
  input  logic               pready,
  input  logic               pslverr,
  input  logic               clr_stats,
  output logic               busy,
  output logic               err_valid,
  output logic [2:0]         err_code,
  output logic [NUM_ERR-1:0] err_sticky,
  output logic [CNT_W-1:0]   rd_cnt,
  output logic [CNT_W-1:0]   wr_cnt,
  output logic [WAIT_W-1:0]  wait_max
);

  mon_state_e         state_q, state_d;
  logic [NUM_ERR-1:0] err_vec, err_hit, sticky_q, sticky_d;
  logic               complete, access_end, wait_inc, capture;
  logic               pwrite_q, unstable;
  logic [WAIT_W-1:0]  wait_cnt, wmax_q, wmax_d, wmax_base;
  logic               err_valid_q;
  logic [2:0]         err_code_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      state_q <= IDLE;
    else if (pclken) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (psel && !penable) state_d = SETUP;
      SETUP: begin
        if (psel && penable) state_d = ACCESS;
        else if (psel)       state_d = SETUP;
        else                 state_d = IDLE;
      end
      ACCESS:  if (!psel || !penable || pready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    busy       = (state_q != IDLE);
    err_vec    = '0;
    complete   = 1'b0;
    access_end = 1'b0;
    wait_inc   = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      IDLE: if (penable) err_vec |= err_bit(ERR_ENABLE_NO_SETUP);
      SETUP: begin
        capture = 1'b1;
        if (!(psel && penable)) err_vec |= err_bit(ERR_SETUP_NO_ENABLE);
      end
      ACCESS: begin
        if (!psel || !penable) begin
          access_end = 1'b1;
          err_vec   |= err_bit(ERR_ACCESS_DROP);
        end else if (pready) begin
          access_end = 1'b1;
          complete   = 1'b1;
          if (pslverr) err_vec |= err_bit(ERR_SLVERR);
        end else begin
          wait_inc = 1'b1;
          // Fires on the wait that takes the counter to the limit, hence once.
          if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) err_vec |= err_bit(ERR_TIMEOUT);
        end
      end
      default: ;
    endcase
    if (unstable) err_vec |= err_bit(ERR_UNSTABLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                pwrite_q <= 1'b0;
    else if (pclken && capture) pwrite_q <= pwrite;
  end

`ifdef APB_MON_STABILITY_CHECK_EN
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              unstable_seen_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q          <= '0;
      wdata_q         <= '0;
      unstable_seen_q <= 1'b0;
    end else if (pclken) begin
      if (capture) begin
        addr_q          <= paddr;
        wdata_q         <= pwdata;
        unstable_seen_q <= 1'b0;
      end else if (unstable) begin
        unstable_seen_q <= 1'b1;
      end
    end
  end

  assign unstable = (state_q == ACCESS) && !unstable_seen_q &&
                    ((paddr != addr_q) || (pwrite != pwrite_q) ||
                     (pwrite_q && (pwdata != wdata_q)));
`else
  logic unused_bus;
  assign unused_bus = ^{paddr, pwdata};
  assign unstable   = 1'b0;
`endif

  // A clear and a new event on the same edge keep the event.
  always_comb begin
    err_hit   = pclken ? err_vec : '0;
    sticky_d  = (clr_stats ? '0 : sticky_q) | err_hit;
    wmax_base = clr_stats ? '0 : wmax_q;
    wmax_d    = (pclken && access_end && (wait_cnt > wmax_base)) ? wait_cnt : wmax_base;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_q    <= '0;
      wmax_q      <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      sticky_q    <= sticky_d;
      wmax_q      <= wmax_d;
      err_valid_q <= |err_hit;
      err_code_q  <= (|err_hit) ? first_err(err_hit) : '0;
    end
  end

  apb_mon_satcnt #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc_i (pclken && wait_inc),
    .clr_i (pclken && capture),
    .cnt_o (wait_cnt)
  );

  apb_mon_satcnt #(.W(CNT_W)) u_rd_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc_i (pclken && complete && !pwrite_q),
    .clr_i (clr_stats),
    .cnt_o (rd_cnt)
  );

  apb_mon_satcnt #(.W(CNT_W)) u_wr_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc_i (pclken && complete && pwrite_q),
    .clr_i (clr_stats),
    .cnt_o (wr_cnt)
  );

  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign err_sticky = sticky_q;
  assign wait_max   = wmax_q;

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Scoreboard bench for apb_protocol_monitor: directed APB sequences push the
// expected error codes; a negedge monitor pops them whenever err_valid is seen.
module tb_apb_protocol_monitor;
  import apb_mon_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        pclken, psel, penable, pwrite, pready, pslverr, clr_stats;
  logic [12:0] paddr;
  logic [31:0] pwdata;
  logic        busy, err_valid;
  logic [2:0]  err_code;
  logic [5:0]  err_sticky;
  logic [15:0] rd_cnt, wr_cnt;
  logic [7:0]  wait_max;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          busy_cnt = 0;
  logic        stretch  = 1'b0;
  logic [2:0]  exp_q[$];

  apb_protocol_monitor #(
    .ADDR_W(13), .DATA_W(32), .TIMEOUT_CYCLES(TIMEOUT), .WAIT_W(8), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .pclken(pclken), .psel(psel), .penable(penable),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pready(pready),
    .pslverr(pslverr), .clr_stats(clr_stats), .busy(busy), .err_valid(err_valid),
    .err_code(err_code), .err_sticky(err_sticky), .rd_cnt(rd_cnt),
    .wr_cnt(wr_cnt), .wait_max(wait_max)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Error monitor: every err_valid pulse must match the oldest expected code.
  always @(negedge clk) begin
    if (reset && err_valid) begin
      if (exp_q.size() == 0) check("err_unexpected", 32'(err_valid), 32'd0);
      else                   check("err_code", 32'(err_code), 32'(exp_q.pop_front()));
    end
  end

  // One sampled bus cycle; in stretch mode an ignored pclken=0 cycle follows
  // with pready inverted.
  task automatic step(input logic s, input logic e, input logic r, input logic se);
    psel = s; penable = e; pready = r; pslverr = se; pclken = 1'b1;
    if (busy) busy_cnt++;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    if (stretch) begin
      pclken = 1'b0; pready = ~r;
      @(posedge clk); #1;
      pclken = 1'b1; pready = r;
    end
  endtask

  task automatic xfer(input logic w, input logic [12:0] a, input logic [31:0] d,
                      input int nwait, input logic se);
    pwrite = w; paddr = a; pwdata = d;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= nwait; i++) begin
      if (i == TIMEOUT) exp_q.push_back(ERR_TIMEOUT);
      step(1'b1, 1'b1, 1'b0, 1'b0);
    end
    if (se) exp_q.push_back(ERR_SLVERR);
    step(1'b1, 1'b1, 1'b1, se);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_stats();
    clr_stats = 1'b1;
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; pclken = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    pready = 1'b0; pslverr = 1'b0; clr_stats = 1'b0; paddr = '0; pwdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    check("rst_sticky", 32'(err_sticky), 32'd0);
    check("rst_rd_cnt", 32'(rd_cnt), 32'd0);
    check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    check("rst_wait_max", 32'(wait_max), 32'd0);
    reset = 1'b1;
    idle();

    // Zero-wait write.
    busy_cnt = 0;
    xfer(1'b1, 13'h010, 32'hDEAD_BEEF, 0, 1'b0);
    idle();
    check("t1_busy_cycles", 32'(busy_cnt), 32'd2);
    check("t1_wr_cnt", 32'(wr_cnt), 32'd1);
    check("t1_wait_max", 32'(wait_max), 32'd0);
    check("t1_sticky", 32'(err_sticky), 32'd0);

    // Read with 16 waits: timeout reported once, transfer still completes.
    busy_cnt = 0;
    xfer(1'b0, 13'h014, 32'h0, 16, 1'b0);
    idle();
    check("t2_busy_cycles", 32'(busy_cnt), 32'd18);
    check("t2_rd_cnt", 32'(rd_cnt), 32'd1);
    check("t2_wr_cnt", 32'(wr_cnt), 32'd1);
    check("t2_wait_max", 32'(wait_max), 32'd16);
    check("t2_sticky", 32'(err_sticky), 32'b001000);

    // Statistics clear, then slave error followed by a back-to-back read.
    clear_stats();
    check("t3_clr_rd", 32'(rd_cnt), 32'd0);
    check("t3_clr_wr", 32'(wr_cnt), 32'd0);
    check("t3_clr_wmax", 32'(wait_max), 32'd0);
    check("t3_clr_sticky", 32'(err_sticky), 32'd0);
    xfer(1'b0, 13'h018, 32'h0, 0, 1'b1);
    check("t3_rd_after_slverr", 32'(rd_cnt), 32'd1);
    xfer(1'b0, 13'h01C, 32'h0, 1, 1'b0);
    idle();
    check("t3_rd_b2b", 32'(rd_cnt), 32'd2);
    check("t3_wait_max", 32'(wait_max), 32'd1);
    check("t3_sticky", 32'(err_sticky), 32'b010000);

    // Enable straight from IDLE, then SETUP abandoned.
    clear_stats();
    exp_q.push_back(ERR_ENABLE_NO_SETUP);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t4_stay_idle", 32'(busy), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(ERR_SETUP_NO_ENABLE);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_back_idle", 32'(busy), 32'd0);
    idle();
    check("t4_sticky", 32'(err_sticky), 32'b000011);
    check("t4_rd_cnt", 32'(rd_cnt), 32'd0);

    // Clock-enable gaps during a 3-wait write; pready during gaps is ignored.
    clear_stats();
    stretch = 1'b1;
    xfer(1'b1, 13'h030, 32'h1234_5678, 3, 1'b0);
    stretch = 1'b0;
    idle();
    check("t5_wr_cnt", 32'(wr_cnt), 32'd1);
    check("t5_wait_max", 32'(wait_max), 32'd3);
    check("t5_rd_cnt", 32'(rd_cnt), 32'd0);

    // Asynchronous reset in the middle of an ACCESS.
    pwrite = 1'b1; paddr = 13'h040; pwdata = 32'hA5A5_A5A5;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_busy_pre_reset", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_wr", 32'(wr_cnt), 32'd0);
    check("t5_async_wmax", 32'(wait_max), 32'd0);
    check("t5_async_sticky", 32'(err_sticky), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    idle();
    check("t5_discarded_wr", 32'(wr_cnt), 32'd0);
    check("t5_idle_after_rst", 32'(busy), 32'd0);

`ifdef APB_MON_STABILITY_CHECK_EN
    // Address changes during ACCESS; clear on the same edge loses to the set.
    pwrite = 1'b1; paddr = 13'h020; pwdata = 32'h0000_00FF;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    paddr = 13'h024;
    clr_stats = 1'b1;
    exp_q.push_back(ERR_UNSTABLE);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    idle();
    check("t6_sticky", 32'(err_sticky), 32'b100000);
    check("t6_wr_cnt", 32'(wr_cnt), 32'd1);
    check("t6_wait_max", 32'(wait_max), 32'd2);
`endif

    idle();
    idle();
    while (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL err_missing: got no err_valid, expected code %0d", exp_q.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
